// File: rtl/mem_interface_pkg.sv
// Shared constants for the multicycle-CPU memory interface: state encoding,
// the NOP reset value of the instruction register and the default wait limit.
package mem_interface_pkg;

    localparam logic [1:0]  STATE_IDLE = 2'd0;
    localparam logic [1:0]  STATE_BUSY = 2'd1;
    localparam logic [1:0]  STATE_DONE = 2'd2;

    localparam logic [31:0] NOP_INST           = 32'h0000_0013;
    localparam int          WAIT_LIMIT_DEFAULT = 15;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_interface_wait_timer.sv
// Wait-cycle counter for outstanding memory requests; saturates at LIMIT and
// flags expiry so the interface can abandon a request that is never acknowledged.
module mem_wait_timer
    import mem_interface_pkg::*;
#(
    parameter int LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    assign o_expired = (r_count == CW'(LIMIT));

    // Count un-acknowledged busy cycles, holding at the limit.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= {CW{1'b0}};
        end else if (i_clear) begin
            r_count <= {CW{1'b0}};
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/mem_interface.sv
// Memory interface between a multicycle CPU controller and a handshaked memory:
// latches one access, holds it until acknowledge or timeout, and stalls the controller.
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic        iIoD,
    input  logic        iIRWrite,
    input  logic [31:0] iPC,
    input  logic [31:0] iALUOut,
    input  logic [31:0] iWriteData,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [31:0] oInst,
    output logic [31:0] oMDR,
    output logic        oStall,
    output logic        oMemErr
);

    logic [1:0]  r_state;
    logic        r_ir_flag;
    logic [31:0] w_addr_sel;
    logic        w_one_strobe;
    logic        w_both_strobes;
    logic        w_bad_request;
    logic        w_accept;
    logic        w_timer_en;
    logic        w_expired;

    assign w_addr_sel     = iIoD ? iALUOut : iPC;
    assign w_one_strobe   = iMemRead ^ iMemWrite;
    assign w_both_strobes = iMemRead & iMemWrite;
    // A misaligned address only matters when a single strobe actually requests it.
    assign w_bad_request  = w_both_strobes | (w_one_strobe & ~is_word_aligned(w_addr_sel));
    assign w_accept       = (r_state == STATE_IDLE) & w_one_strobe & ~w_bad_request;
    assign w_timer_en     = (r_state == STATE_BUSY) & ~iMemAck;

    mem_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .i_clk     (iClk),
        .i_rst     (iRst),
        .i_clear   (w_accept),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    // Stall the controller while a request is being issued or is outstanding.
    always_comb begin
        oStall = 1'b0;
        case (r_state)
            STATE_IDLE: oStall = iMemRead | iMemWrite;
            STATE_BUSY: oStall = 1'b1;
            STATE_DONE: oStall = 1'b0;
            default:    oStall = 1'b0;
        endcase
    end

    // Access FSM with registered memory-side outputs and data registers.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_state   <= STATE_IDLE;
            r_ir_flag <= 1'b0;
            oMemReq   <= 1'b0;
            oMemWe    <= 1'b0;
            oMemAddr  <= 32'h0000_0000;
            oMemWData <= 32'h0000_0000;
            oMDR      <= 32'h0000_0000;
            oInst     <= NOP_INST;
            oMemErr   <= 1'b0;
        end else begin
            oMemErr <= 1'b0;
            case (r_state)
                STATE_IDLE: begin
                    if (w_bad_request) begin
                        oMemErr <= 1'b1;
                        r_state <= STATE_DONE;
                    end else if (w_one_strobe) begin
                        oMemAddr  <= w_addr_sel;
                        oMemWData <= iWriteData;
                        oMemWe    <= iMemWrite;
                        r_ir_flag <= iIRWrite;
                        oMemReq   <= 1'b1;
                        r_state   <= STATE_BUSY;
                    end else begin
                        r_state <= STATE_IDLE;
                    end
                end
                STATE_BUSY: begin
                    if (iMemAck) begin
                        if (!oMemWe) begin
                            oMDR <= iMemRData;
                            if (r_ir_flag) begin
                                oInst <= iMemRData;
                            end
                        end
                        oMemReq <= 1'b0;
                        oMemWe  <= 1'b0;
                        r_state <= STATE_DONE;
                    end else if (w_expired) begin
                        oMemErr <= 1'b1;
                        oMemReq <= 1'b0;
                        oMemWe  <= 1'b0;
                        r_state <= STATE_DONE;
                    end else begin
                        r_state <= STATE_BUSY;
                    end
                end
                STATE_DONE: begin
                    r_state <= STATE_IDLE;
                end
                default: begin
                    oMemReq <= 1'b0;
                    oMemWe  <= 1'b0;
                    r_state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 The clock and reset SHALL be: one clock; reset is synchronous and active-low. Ports are iClk and iRst.
REQ-002 Parameter WAIT_LIMIT SHALL default to 15 and sets the maximum BUSY cycles allowed without acknowledge.
REQ-003 Port iClk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port iRst SHALL be input, 1 bit: synchronous active-low reset.
REQ-005 Port iMemRead SHALL be input, 1 bit: read strobe from the controller.
REQ-006 Port iMemWrite SHALL be input, 1 bit: write strobe from the controller.
REQ-007 Port iIoD SHALL be input, 1 bit: address select; 0 selects PC, 1 selects ALUOut.
REQ-008 Port iIRWrite SHALL be input, 1 bit: the read data also loads the instruction register.
REQ-009 Ports iPC, iALUOut and iWriteData SHALL be inputs, 32 bits each: PC, ALU result and store data.
REQ-010 Port iMemAck SHALL be input, 1 bit, and port iMemRData SHALL be input, 32 bits: memory acknowledge and read data.
REQ-011 Ports oMemReq and oMemWe SHALL be outputs, 1 bit each: memory request and write enable.
REQ-012 Ports oMemAddr and oMemWData SHALL be outputs, 32 bits each: memory address and write data.
REQ-013 Ports oInst and oMDR SHALL be outputs, 32 bits each: instruction register and memory data register.
REQ-014 Port oStall SHALL be output, 1 bit, and port oMemErr SHALL be output, 1 bit: controller hold and a one-cycle error pulse.

Function
REQ-015 The FSM SHALL have three states, IDLE, BUSY and DONE, and SHALL enter IDLE out of reset.
REQ-016 In IDLE, when exactly one of iMemRead/iMemWrite is 1, the block SHALL:
- latch the address (iIoD ? iALUOut : iPC), iWriteData, the write flag and iIRWrite;
- clear the wait counter;
- go to BUSY.
REQ-017 oStall SHALL be combinational: 1 when (IDLE and (iMemRead or iMemWrite)) or in BUSY; 0 otherwise.
REQ-018 In BUSY, oMemReq SHALL be 1, oMemWe SHALL equal the latched write flag, and oMemAddr/oMemWData SHALL hold the latched values, stable until acknowledged.
REQ-019 On BUSY with iMemAck=1, a read SHALL load iMemRData into oMDR, and also into oInst if the latched IR flag is 1; the next state SHALL be DONE.
REQ-020 A write SHALL leave oMDR and oInst unchanged.
REQ-021 The wait counter SHALL increment each BUSY cycle without acknowledge. At count==WAIT_LIMIT with no acknowledge, the block SHALL pulse oMemErr for one cycle, drop the request and go to DONE.
REQ-022 In IDLE, a request that is misaligned (address[1:0]!=0) or has both strobes at 1 SHALL issue no access, pulse oMemErr on the next cycle, and go to DONE.
REQ-023 DONE SHALL last exactly one cycle with oStall=0 and oMemReq=0, SHALL ignore the strobes, and SHALL then return to IDLE.
REQ-024 Minimum access latency SHALL be: request in cycle N, oMemReq in N+1, acknowledge in N+1, DONE in N+2, controller advances at the end of N+2.
REQ-025 oMemReq SHALL be 0 in IDLE and DONE; iMemAck outside BUSY SHALL be ignored.

Reset
REQ-026 On iRst=0 at a clock edge, the block SHALL go to IDLE, clear the wait counter, and set oMemReq=0, oMemWe=0, oMemAddr=0, oMemWData=0, oMDR=0, oMemErr=0 and oInst=32'h0000_0013 (NOP).
REQ-027 A reset during BUSY SHALL drop oMemReq at that same edge, and a late iMemAck SHALL have no effect.

Structure
REQ-028 A shared package SHALL hold the state encoding, the NOP constant and the WAIT_LIMIT default.
REQ-029 The wait counter SHALL be a sub-module named mem_wait_timer, with clear, enable and expired ports.

Verification
REQ-030 Read with iIoD=0, iPC=0x40, iIRWrite=1, acknowledge on the first BUSY cycle, iMemRData=0x00500093 SHALL give oInst=oMDR=0x00500093, oStall high for 2 cycles, oMemAddr=0x40.
REQ-031 Write with iIoD=1, iALUOut=0x100, iWriteData=0xDEADBEEF, acknowledge after 3 cycles SHALL give oMemWe=1, stable address/data for 3 cycles, oMDR unchanged.
REQ-032 Read with iALUOut=0x102 SHALL give no oMemReq, an oMemErr pulse, and DONE.
REQ-033 Read with no acknowledge SHALL give an oMemErr pulse after 15 BUSY cycles, then DONE, then IDLE.
REQ-034 iRst=0 during BUSY, followed by iMemAck=1, SHALL give oMemReq=0, oInst=0x00000013, and oMDR=0.
REQ-035 Both strobes at 1 SHALL give oMemErr with no access.
